// File: rtl/vec_mem_pkg.sv
// vec_mem_pkg: shared states and geometry for the vector memory sequencer.
package vec_mem_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LANES = 4;
  localparam int DEF_ADDR_W = 32;
  localparam int WORD_BYTES = DEF_DATA_W / 8;
  localparam int BEAT_W = $clog2(DEF_LANES);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} vms_state_t;
endpackage

// File: rtl/vec_mem_sequencer_lane_buffer.sv
// vec_lane_buffer: load-capture lanes with per-lane enables plus latched store lanes with a beat read mux.
module vec_lane_buffer #(
  parameter int DATA_W = 32,
  parameter int LANES = 4,
  parameter int BW = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [LANES-1:0]         cap_we_i,
  input  logic [DATA_W-1:0]        cap_word_i,
  input  logic                     st_load_i,
  input  logic [DATA_W*LANES-1:0]  st_vec_i,
  input  logic [BW-1:0]            rd_lane_i,
  output logic [DATA_W-1:0]        rd_word_o,
  output logic [DATA_W*LANES-1:0]  rdata_vec_o
);
  logic [LANES-1:0][DATA_W-1:0] ld_q, st_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld_q <= '0;
      st_q <= '0;
    end else begin
      if (st_load_i) st_q <= st_vec_i;
      for (int i = 0; i < LANES; i++)
        if (cap_we_i[i]) ld_q[i] <= cap_word_i;
    end
  end
  assign rd_word_o = st_q[rd_lane_i];
  assign rdata_vec_o = ld_q;
endmodule

// File: rtl/vec_mem_sequencer.sv
// vec_mem_sequencer: splits a vector load/store into per-lane beats on a scalar memory port.
module vec_mem_sequencer
  import vec_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANES = DEF_LANES,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     is_store,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [DATA_W*LANES-1:0]  wdata_vec,
  output logic                     stall,
  output logic                     done,
  output logic [DATA_W*LANES-1:0]  rdata_vec,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_ready
);
  localparam logic [BEAT_W-1:0] LAST = BEAT_W'(LANES - 1);
  localparam logic [ADDR_W-1:0] MASK = ~ADDR_W'(WORD_BYTES - 1);
  vms_state_t state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d, rd_lane;
  logic mem_req_q, mem_req_d, we_q, we_d, done_q, done_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, st_word;
  logic [LANES-1:0] cap_we;
  logic go, hs, last, step;
  assign go = (state_q == IDLE) & start;
  assign hs = (state_q == ACCESS) & mem_ready;
  assign last = beat_q == LAST;
  assign step = hs & ~last;
  assign rd_lane = beat_q + 1'b1;
  always_comb begin
    state_d = go ? ACCESS : (hs && last) ? DONE : (state_q == DONE) ? IDLE : state_q;
    beat_d = go ? '0 : step ? beat_q + 1'b1 : beat_q;
    mem_req_d = go ? 1'b1 : (hs && last) ? 1'b0 : mem_req_q;
    we_d = go ? is_store : we_q;
    mem_addr_d = go ? (base_addr & MASK) : step ? mem_addr_q + ADDR_W'(WORD_BYTES) : mem_addr_q;
    mem_wdata_d = go ? wdata_vec[DATA_W-1:0] : step ? st_word : mem_wdata_q;
    done_d = hs & last;
  end
  // only loads capture; stores leave the assembled vector untouched
  always_comb begin
    cap_we = '0;
    if (hs && !we_q) cap_we[beat_q] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q <= '0;
      mem_req_q <= 1'b0;
      we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      mem_req_q <= mem_req_d;
      we_q <= we_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q <= done_d;
    end
  end
  vec_lane_buffer #(.DATA_W(DATA_W), .LANES(LANES), .BW(BEAT_W)) u_buf (
    .clk(clk),
    .rst_n(rst_n),
    .cap_we_i(cap_we),
    .cap_word_i(mem_rdata),
    .st_load_i(go),
    .st_vec_i(wdata_vec),
    .rd_lane_i(rd_lane),
    .rd_word_o(st_word),
    .rdata_vec_o(rdata_vec)
  );
  assign stall = go | (state_q == ACCESS);
  assign done = done_q;
  assign mem_req = mem_req_q;
  assign mem_we = we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_vec_mem_sequencer.sv
// tb_vec_mem_sequencer: table-driven ops with a beat/result scoreboard plus hand-written corner sequences.
module tb_vec_mem_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic is_store = 1'b0;
  logic [31:0] base_addr = '0;
  logic [127:0] wdata_vec = '0;
  logic stall, done, mem_req, mem_we;
  logic [127:0] rdata_vec;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic mem_ready = 1'b1;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int stall_left = 0;
  logic [31:0] stall_addr = 32'hFFFF_FFFF;
  logic [127:0] rd_model = '0;

  typedef struct {logic we; logic [31:0] addr; logic [31:0] wd;} beat_t;
  typedef struct {logic st; logic [31:0] base; logic [127:0] wv; logic [127:0] exp; int lat;} vec_t;
  beat_t bq[$];
  logic [127:0] dq[$];
  beat_t mb;

  vec_mem_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
    .base_addr(base_addr), .wdata_vec(wdata_vec), .stall(stall), .done(done),
    .rdata_vec(rdata_vec), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h100: return 32'h11111111;
      32'h104: return 32'h22222222;
      32'h108: return 32'h33333333;
      32'h10C: return 32'h44444444;
      default: return {~a[15:0], a[15:0]};
    endcase
  endfunction
  assign mem_rdata = mem_rd(mem_addr);

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (mem_req && mem_addr == stall_addr && stall_left > 0) begin
      mem_ready = 1'b0;
      stall_left--;
    end else mem_ready = 1'b1;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req && mem_ready) begin
        if (bq.size() == 0) chk("beat_unexpected", 1, 0);
        else begin
          mb = bq.pop_front();
          chk("beat_addr", mem_addr, mb.addr);
          chk("beat_we", mem_we, mb.we);
          if (mb.we) chk("beat_wdata", mem_wdata, mb.wd);
        end
      end else if (mem_req) chk("hold_addr", mem_addr, stall_addr);
      if (done) begin
        done_cnt++;
        if (dq.size() == 0) chk("done_unexpected", 1, 0);
        else chk("rdata_vec", rdata_vec, dq.pop_front());
      end
    end
  end

  task automatic push_op(input logic st, input logic [31:0] base, input logic [127:0] wv, input logic [127:0] exp);
    beat_t b;
    for (int i = 0; i < 4; i++) begin
      b.we = st;
      b.addr = (base & 32'hFFFF_FFFC) + 32'(4 * i);
      b.wd = wv[i*32 +: 32];
      bq.push_back(b);
    end
    dq.push_back(exp);
  endtask

  task automatic run_op(input logic st, input logic [31:0] base, input logic [127:0] wv,
                        input logic [127:0] exp, input int lat, input int hold);
    int cyc;
    bit got;
    cyc = 0;
    got = 0;
    @(posedge clk); #1;
    start = 1'b1; is_store = st; base_addr = base; wdata_vec = wv;
    push_op(st, base, wv, exp);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
      chk("stall_busy", stall, 1);
      @(posedge clk); #1;
      cyc++;
      start = cyc < hold;
    end
    chk("done_seen", got, 1);
    chk("latency", cyc, lat);
    chk("stall_done", stall, 0);
    @(posedge clk); #1;
    start = 1'b0;
    rd_model = exp;
  endtask

  vec_t tbl[5];
  int dbefore;

  initial begin
    tbl[0] = '{1'b0, 32'h100, 128'h0, 128'h44444444_33333333_22222222_11111111, 5};
    tbl[1] = '{1'b1, 32'h20, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 128'h44444444_33333333_22222222_11111111, 5};
    tbl[2] = '{1'b0, 32'h103, 128'h0, 128'h44444444_33333333_22222222_11111111, 5};
    tbl[3] = '{1'b0, 32'hFFFF_FFF8, 128'h0, 128'hFFFB0004_FFFF0000_0003FFFC_0007FFF8, 5};
    tbl[4] = '{1'b1, 32'hFFFF_FFFC, 128'h01234567_89ABCDEF_DEADBEEF_CAFEF00D, 128'hFFFB0004_FFFF0000_0003FFFC_0007FFF8, 5};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_done", done, 0);
    chk("rst_stall", stall, 0);
    chk("rst_rdata", rdata_vec, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    foreach (tbl[i]) run_op(tbl[i].st, tbl[i].base, tbl[i].wv, tbl[i].exp, tbl[i].lat, 1);
    stall_addr = 32'h308;
    stall_left = 3;
    run_op(1'b0, 32'h300, 128'h0, 128'hFCF3030C_FCF70308_FCFB0304_FCFF0300, 8, 1);
    @(posedge clk); #1;
    start = 1'b1; is_store = 1'b0; base_addr = 32'h200;
    push_op(1'b0, 32'h200, 128'h0, 128'h0);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_beat1_addr", mem_addr, 32'h204);
    rst_n = 1'b0;
    dbefore = done_cnt;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bq.delete();
    dq.delete();
    @(negedge clk);
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_stall", stall, 0);
    chk("midrst_rdata", rdata_vec, 0);
    chk("midrst_done", done, 0);
    repeat (3) @(posedge clk);
    chk("midrst_no_done", done_cnt, dbefore);
    rd_model = '0;
    run_op(1'b0, 32'h100, 128'h0, 128'h44444444_33333333_22222222_11111111, 5, 1);
    dbefore = done_cnt;
    run_op(1'b1, 32'h40, 128'h44440004_33330003_22220002_11110001, rd_model, 5, 6);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("held_one_done", done_cnt, dbefore + 1);
    chk("held_idle_req", mem_req, 0);
    chk("held_no_beats", bq.size(), 0);
    chk("held_rdata", rdata_vec, rd_model);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vec_mem_sequencer.md
Name: vec_mem_sequencer

Overview:
- Multi-beat sequencer for vector loads and stores in the Memory stage of the SIMD AES pipeline.
- Receives a vector memory request when the decoded MemData/VecData/MemWrite controls reach Memory, and splits the LANES*DATA_W vector into LANES word beats on a scalar memory port.
- Stalls the pipeline until all beats complete, then presents the assembled load vector for writeback.

Parameters:
- DATA_W, 32, width of one memory word / vector lane.
- LANES, 4, lanes per vector (vector width = DATA_W*LANES = 128).
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  vector memory op present in Memory stage (VecData & MemData).
- is_store  in  1  1 = vector store (MemWrite), 0 = vector load; sampled with start.
- base_addr  in  ADDR_W  byte address of lane 0; sampled with start.
- wdata_vec  in  DATA_W*LANES  store data, lane i = bits [i*DATA_W +: DATA_W]; sampled with start.
- stall  out  1  freeze Fetch..Memory pipeline registers.
- done  out  1  one-cycle pulse, operation complete.
- rdata_vec  out  DATA_W*LANES  assembled load vector, lane i from beat i.
- mem_req  out  1  beat request valid.
- mem_we  out  1  beat is a write.
- mem_addr  out  ADDR_W  beat byte address.
- mem_wdata  out  DATA_W  beat write data.
- mem_rdata  in  DATA_W  read data, valid in the handshake cycle.
- mem_ready  in  1  memory accepts/completes the beat; handshake = mem_req & mem_ready.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE, beat=0, all registered outputs 0 (mem_req, mem_we, mem_addr, mem_wdata, done, rdata_vec). Applies mid-operation: the transfer is abandoned, no done pulse, partially loaded lanes are cleared.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - On start=1, latch is_store, base_addr with bits [log2(DATA_W/8)-1:0] forced to 0, and wdata_vec.
  - Set beat=0 and go to ACCESS.
  - start while not IDLE is ignored.
- ACCESS:
  - mem_req=1, mem_we=latched is_store, mem_addr=base + beat*(DATA_W/8) (mod 2^ADDR_W; wrap permitted), mem_wdata=latched lane[beat].
  - These are registered outputs and stay stable until the handshake.
  - On handshake of a load: rdata_vec lane[beat] <= mem_rdata.
  - On handshake with beat<LANES-1: beat++.
  - On handshake with beat=LANES-1: mem_req <= 0, go to DONE.
  - mem_ready low holds state indefinitely, with no timeout.
- DONE: done=1 for exactly one cycle, stall=0, then go to IDLE.
- stall = (IDLE & start) | ACCESS. It is combinational on start, so the pipeline freezes in the request cycle.
- Latency with mem_ready tied 1: start at cycle 0, beats in cycles 1..LANES, done in cycle LANES+1. Total stall = LANES+1 cycles.
- rdata_vec holds its value after done until the next load handshake overwrites lanes. Stores never modify rdata_vec.
- Only one op is in flight at a time. Lane order is always 0..LANES-1, ascending addresses.

Decomposition:
- Package vec_mem_pkg:
  - state enum vms_state_t {IDLE, ACCESS, DONE};
  - localparam WORD_BYTES = DATA_W/8;
  - localparam BEAT_W = $clog2(LANES).
- One natural sub-module, vec_lane_buffer:
  - LANES×DATA_W register file with a per-lane write enable (load capture) and a lane read mux (store beat select);
  - synchronous active-low reset clears it.
- The FSM, beat counter and address generation stay in vec_mem_sequencer.

Test Plan:
- Load, mem_ready=1, base=0x100, memory words 0x11111111/0x22222222/0x33333333/0x44444444 at 0x100..0x10C:
  - mem_addr sequence 0x100,0x104,0x108,0x10C;
  - done at cycle 5;
  - rdata_vec=0x44444444_33333333_22222222_11111111;
  - stall high cycles 0..4.
- Store, base=0x20, wdata_vec=0xDDDD_CCCC_BBBB_AAAA (16-bit fields scaled to 32-bit lanes): 4 beats with mem_we=1 in lane order at 0x20..0x2C; rdata_vec unchanged.
- Load with mem_ready low for 3 cycles on beat 2: mem_addr=base+8 and mem_req stay stable; done arrives 3 cycles late; data correct.
- Misaligned base 0x103 and wrap base 0xFFFFFFF8:
  - misaligned: addresses 0x100..0x10C;
  - wrap: 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- rst_n=0 during beat 1: next cycle IDLE, mem_req=0, stall=0, rdata_vec=0, no done pulse. A new start afterwards completes normally.
- start held high through ACCESS and DONE: exactly one operation and one done pulse; a second op starts only when start is seen in IDLE.
